// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: shift-op encoding, FSM states and
// the raw-op decoder.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Largest distance covered in a single step; smaller remainders go one bit at a time.
  localparam int unsigned BigStep = 4;

  // The reserved encoding 2'b11 behaves as a left shift.
  function automatic shift_op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   return SHIFT_SRL;
      2'b10:   return SHIFT_SRA;
      default: return SHIFT_SLL;
    endcase
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle between a requester (master) and the
// shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
);

  logic                   start_valid;
  logic                   start_ready;
  logic [1:0]             op;
  logic [DATA_WIDTH-1:0]  src_a;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   result_valid;
  logic                   result_ready;
  logic [DATA_WIDTH-1:0]  result;
  logic                   busy;

  modport master (
    output start_valid,
    output op,
    output src_a,
    output shamt,
    output result_ready,
    input  start_ready,
    input  result_valid,
    input  result,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  op,
    input  src_a,
    input  shamt,
    input  result_ready,
    output start_ready,
    output result_valid,
    output result,
    output busy
  );

endinterface

// File: rtl/shift_step.sv
// Combinational single shift step: moves the operand by 1 or 4 bit positions
// in the direction and fill mode selected by the op.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  shift_op_e             op_i,
  input  logic                  big_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [2:0] amt;

  always_comb begin
    amt = big_i ? 3'd4 : 3'd1;
    case (op_i)
      SHIFT_SRL: data_o = data_i >> amt;
      // Sign bit of the captured operand survives every step, so replicating the
      // current MSB is the same as replicating the original bit DATA_WIDTH-1.
      SHIFT_SRA: data_o = $signed(data_i) >>> amt;
      default:   data_o = data_i << amt;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one command, shifts by 4 while at least four
// positions remain and by 1 otherwise, then holds the result until taken.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input logic              clk,
  input logic              reset,
  shift_sequencer_if.slave bus
);

  state_e                 state_q, state_d;
  shift_op_e              op_q, op_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] rem_q, rem_d;

  logic                   big_step;
  logic [SHAMT_WIDTH-1:0] step_amt;
  logic [DATA_WIDTH-1:0]  step_out;

  always_comb begin
    big_step = 32'(rem_q) >= BigStep;
    step_amt = big_step ? SHAMT_WIDTH'(BigStep) : SHAMT_WIDTH'(1);
  end

  shift_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .op_i  (op_q),
    .big_i (big_step),
    .data_i(acc_q),
    .data_o(step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          op_d    = decode_op(bus.op);
          acc_d   = bus.src_a;
          rem_d   = bus.shamt;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = step_out;
        rem_d = rem_q - step_amt;
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= SHIFT_SLL;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    bus.start_ready  = (state_q == IDLE);
    bus.result_valid = (state_q == DONE);
    bus.busy         = (state_q != IDLE);
    bus.result       = acc_q;
  end

  a_shift_has_work: assert property (
    @(posedge clk) disable iff (reset) (state_q == SHIFT) |-> (rem_q != '0)
  );

  a_result_held: assert property (
    @(posedge clk) disable iff (reset)
    (bus.result_valid && !bus.result_ready) |=> (bus.result_valid && $stable(bus.result))
  );

endmodule
